// File: rtl/uart_pkg.sv
// Shared types and defaults for the configurable UART receiver.
// Parity encodings, receiver FSM states, default parameters.
package uart_pkg;

  localparam int DEF_DATABITS   = 8;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_DIV_WIDTH  = 16;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_ODD   = 2'b10;
  localparam logic [1:0] PAR_NONE3 = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead receive FIFO for the UART receiver.
// A push when full only lands if a pop frees the slot.
module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, do_pop, do_push;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign valid   = ~empty;
  assign count   = count_q;
  assign dout    = empty ? '0 : mem[rd_q];

  // Pointer and occupancy update.
  always_comb begin
    wr_d    = do_push ? wr_q + PW'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + PW'(1) : rd_q;
    count_d = count_q;
    if (do_push && !do_pop)
      count_d = count_q + CW'(1);
    else if (do_pop && !do_push)
      count_d = count_q - CW'(1);
  end

  // Storage array; contents are masked while empty.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_q] <= din;
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with runtime baud/parity/stop config.
// Frames and their error flags queue in a small show-ahead FIFO.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATABITS   = DEF_DATABITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              rx_line,
  input  logic [DIV_WIDTH-1:0]              baud_div,
  input  logic [1:0]                        parity_mode,
  input  logic                              stop_bits,
  input  logic                              rd_en,
  input  logic                              clr_overrun,
  output logic [DATABITS-1:0]               rd_data,
  output logic                              rd_valid,
  output logic                              parity_error,
  output logic                              framing_error,
  output logic                              overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATABITS);
  localparam int FW  = DATABITS + 2;
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE-1);
  localparam logic [OSW-1:0] OS_MID  = OSW'(OVERSAMPLE/2);
  localparam logic [OSW-1:0] OS_M1   = OSW'(OVERSAMPLE/2-1);
  localparam logic [OSW-1:0] OS_P1   = OSW'(OVERSAMPLE/2+1);

  rx_state_e            state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_WIDTH-1:0] div_act_q, div_act_d, div_eff;
  logic [OSW-1:0]       os_cnt_q, os_cnt_d;
  logic                 smp0_q, smp0_d, smp1_q, smp1_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATABITS-1:0]  shreg_q, shreg_d;
  logic [1:0]           pmode_q, pmode_d;
  logic                 stop2_q, stop2_d, stop_idx_q, stop_idx_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 push_q, push_d;
  logic [FW-1:0]        push_data_q, push_data_d;
  logic                 overrun_q, overrun_d;
  logic                 rx_s, fall, tick, maj, maj_tick, par_on;
  logic                 fifo_drop;
  logic [FW-1:0]        head;

  assign rx_s     = sync2_q;
  assign fall     = prev_q & ~rx_s;
  assign div_eff  = (div_act_q == '0) ? DIV_WIDTH'(1) : div_act_q;
  assign tick     = (div_cnt_q == div_eff - DIV_WIDTH'(1));
  assign maj      = (smp0_q & smp1_q) | (smp0_q & rx_s) | (smp1_q & rx_s);
  assign maj_tick = tick && (os_cnt_q == OS_P1);
  assign par_on   = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);

  // Two-flop synchroniser plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_line;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Tick/oversample timing and the frame state machine.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q + DIV_WIDTH'(1);
    div_act_d   = div_act_q;
    os_cnt_d    = os_cnt_q;
    smp0_d      = smp0_q;
    smp1_d      = smp1_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    pmode_d     = pmode_q;
    stop2_d     = stop2_q;
    stop_idx_d  = stop_idx_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    if (tick) begin
      div_cnt_d = '0;
      div_act_d = baud_div;
      os_cnt_d  = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OSW'(1);
    end
    if (tick && os_cnt_q == OS_M1)
      smp0_d = rx_s;
    if (tick && os_cnt_q == OS_MID)
      smp1_d = rx_s;
    unique case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d   = S_START;
          div_cnt_d = '0;
          os_cnt_d  = '0;
        end
      end
      S_START: begin
        if (tick && os_cnt_q == OS_MID) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            pmode_d    = parity_mode;
            stop2_d    = stop_bits;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
          end
        end else if (maj_tick) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (maj_tick) begin
          shreg_d = {maj, shreg_q[DATABITS-1:1]};
          if (bit_idx_q == BW'(DATABITS-1))
            state_d = par_on ? S_PARITY : S_STOP;
          else
            bit_idx_d = bit_idx_q + BW'(1);
        end
      end
      S_PARITY: begin
        if (maj_tick) begin
          perr_d  = ((^shreg_q) ^ maj) != (pmode_q == PAR_ODD);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (maj_tick) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
            ferr_d     = ferr_q | ~maj;
          end else begin
            push_d      = 1'b1;
            push_data_d = {ferr_q | ~maj, perr_q, shreg_q};
            state_d     = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      div_act_q   <= '0;
      os_cnt_q    <= '0;
      smp0_q      <= 1'b1;
      smp1_q      <= 1'b1;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      pmode_q     <= PAR_NONE;
      stop2_q     <= 1'b0;
      stop_idx_q  <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      div_act_q   <= div_act_d;
      os_cnt_q    <= os_cnt_d;
      smp0_q      <= smp0_d;
      smp1_q      <= smp1_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      pmode_q     <= pmode_d;
      stop2_q     <= stop2_d;
      stop_idx_q  <= stop_idx_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      overrun_q   <= overrun_d;
    end
  end

  // Sticky overrun; a fresh drop beats a clear.
  always_comb begin
    overrun_d = overrun_q;
    if (fifo_drop)
      overrun_d = 1'b1;
    else if (clr_overrun)
      overrun_d = 1'b0;
  end

  uart_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_q),
    .din   (push_data_q),
    .pop   (rd_en),
    .dout  (head),
    .valid (rd_valid),
    .count (fifo_count),
    .drop  (fifo_drop)
  );

  assign rd_data       = head[DATABITS-1:0];
  assign parity_error  = head[DATABITS];
  assign framing_error = head[DATABITS+1];
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg with a frame-level queue model.
// 16x oversample, baud_div 4: 64 clk per bit.
module tb_uart_rx_cfg;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_line = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic [1:0]  parity_mode = 2'b00;
  logic        stop_bits = 1'b0;
  logic        rd_en = 1'b0;
  logic        clr_overrun = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid, parity_error, framing_error, overrun;
  logic [2:0]  fifo_count;

  ent_t mq[$];
  bit   m_ovr = 1'b0;
  bit   chk_en = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  uart_rx_cfg dut (
    .clk           (clk),
    .reset         (reset),
    .rx_line       (rx_line),
    .baud_div      (baud_div),
    .parity_mode   (parity_mode),
    .stop_bits     (stop_bits),
    .rd_en         (rd_en),
    .clr_overrun   (clr_overrun),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .overrun       (overrun),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model compare on every quiet cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", 32'(rd_valid), 32'(mq.size() != 0));
      chk("m_count", 32'(fifo_count), 32'(mq.size()));
      chk("m_ovr", 32'(overrun), 32'(m_ovr));
      if (mq.size() != 0) begin
        chk("m_data", 32'(rd_data), 32'(mq[0].d));
        chk("m_perr", 32'(parity_error), 32'(mq[0].pe));
        chk("m_ferr", 32'(framing_error), 32'(mq[0].fe));
      end
    end
  end

  task automatic bitt(input logic b);
    rx_line = b;
    repeat (64) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] pm,
                      input bit sb, input bit bad_par,
                      input bit stop_low);
    logic pbit;
    bit   pon;
    ent_t e;
    pon = (pm == 2'b01) || (pm == 2'b10);
    pbit = ((pm == 2'b10) ? ~(^d) : (^d)) ^ bad_par;
    @(negedge clk);
    chk_en = 1'b0;
    parity_mode = pm;
    stop_bits = sb;
    bitt(1'b0);
    for (int i = 0; i < 8; i++) bitt(d[i]);
    if (pon) bitt(pbit);
    bitt(~stop_low);
    if (sb) bitt(~stop_low);
    if (stop_low) begin
      rx_line = 1'b0;
      repeat (1280) @(negedge clk);
      rx_line = 1'b1;
    end
    repeat (16) @(negedge clk);
    e.d = d;
    e.pe = pon ? (((^d) ^ pbit) != (pm == 2'b10)) : 1'b0;
    e.fe = stop_low;
    if (mq.size() < 4) mq.push_back(e);
    else m_ovr = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic pop1();
    @(negedge clk);
    chk_en = 1'b0;
    rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
    chk_en = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    reset = 1'b1;
    chk_en = 1'b1;
    repeat (20) @(negedge clk);

    send(8'h55, 2'b01, 1'b0, 1'b0, 1'b0);
    chk("t1_data", 32'(rd_data), 32'h55);
    chk("t1_perr", 32'(parity_error), 32'd0);
    chk("t1_ferr", 32'(framing_error), 32'd0);
    chk("t1_count", 32'(fifo_count), 32'd1);
    pop1();

    send(8'hA3, 2'b10, 1'b0, 1'b1, 1'b0);
    chk("t2_data", 32'(rd_data), 32'hA3);
    chk("t2_perr", 32'(parity_error), 32'd1);
    pop1();

    send(8'h3C, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("t3_count", 32'(fifo_count), 32'd1);
    chk("t3_ferr", 32'(framing_error), 32'd1);
    chk("t3_data", 32'(rd_data), 32'h3C);
    pop1();

    @(negedge clk);
    rx_line = 1'b0;
    repeat (16) @(negedge clk);
    rx_line = 1'b1;
    repeat (300) @(negedge clk);
    chk("t4_glitch_count", 32'(fifo_count), 32'd0);
    send(8'h81, 2'b11, 1'b1, 1'b0, 1'b0);
    chk("t4_data", 32'(rd_data), 32'h81);
    chk("t4_count", 32'(fifo_count), 32'd1);
    pop1();
    pop1();
    chk("t4_empty_pop", 32'(fifo_count), 32'd0);

    for (int k = 1; k <= 5; k++)
      send(8'(k), 2'b00, 1'b0, 1'b0, 1'b0);
    chk("t5_count", 32'(fifo_count), 32'd4);
    chk("t5_ovr", 32'(overrun), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      chk("t5_pop", 32'(rd_data), 32'(k));
      pop1();
    end
    @(negedge clk);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    m_ovr = 1'b0;
    chk("t5_clr", 32'(overrun), 32'd0);

    send(8'hA3, 2'b10, 1'b0, 1'b1, 1'b0);
    chk("t6_pre_count", 32'(fifo_count), 32'd1);
    chk_en = 1'b0;
    @(negedge clk);
    parity_mode = 2'b00;
    bitt(1'b0);
    bitt(1'b1);
    bitt(1'b0);
    bitt(1'b0);
    rx_line = 1'b1;
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_valid", 32'(rd_valid), 32'd0);
    chk("t6_count", 32'(fifo_count), 32'd0);
    chk("t6_data", 32'(rd_data), 32'd0);
    chk("t6_perr", 32'(parity_error), 32'd0);
    chk("t6_ferr", 32'(framing_error), 32'd0);
    chk("t6_ovr", 32'(overrun), 32'd0);
    mq.delete();
    m_ovr = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    repeat (30) @(negedge clk);
    send(8'hC7, 2'b01, 1'b1, 1'b0, 1'b0);
    chk("t6_c7_data", 32'(rd_data), 32'hC7);
    chk("t6_c7_perr", 32'(parity_error), 32'd0);
    chk("t6_c7_ferr", 32'(framing_error), 32'd0);
    chk("t6_c7_count", 32'(fifo_count), 32'd1);
    pop1();
    repeat (5) @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
